// File: rtl/ungrouper.sv
`timescale 1ns/1ps
// ungrouper
//   Serializes a BYTES-wide word into a stream of bytes for a UART
//   transmitter, most significant byte first. A one-word buffer (pend)
//   allows the next word to be loaded while the current one is sent.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   data_in   word to serialize (W = 8*BYTES bits)
//   w_en      one-cycle load strobe for data_in
//   ready     word buffer empty; a w_en will be accepted
//   data_out  byte presented to the transmitter
//   tx_start  one-cycle send request for data_out
//   tx_busy   transmitter is shifting a byte
//   busy      serialization in progress
//   done      one-cycle pulse after the last byte of a word
//   overrun   sticky: w_en arrived while ready was low
module ungrouper #(
  parameter int BYTES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BYTES-1:0] data_in,
  input  logic               w_en,
  output logic               ready,
  output logic [7:0]         data_out,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int W  = 8 * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t        state;
  logic [W-1:0]  pend;
  logic          pend_valid;
  logic [W-1:0]  sh;
  logic [W-1:0]  sh_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          take;

  assign accept  = w_en & ready;
  // The done cycle is itself not allowed to launch the pending word, so a
  // prefetched word always sees done, one IDLE transfer cycle, then tx_start.
  assign take    = (state == IDLE) & pend_valid & ~done;
  assign sh_next = sh << 8;

  // Word buffer. ready mirrors !pend_valid as a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      pend_valid <= 1'b0;
      ready      <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        pend       <= data_in;
        pend_valid <= 1'b1;
        ready      <= 1'b0;
      end else if (take) begin
        pend_valid <= 1'b0;
        ready      <= 1'b1;
      end
      if (w_en && !ready)
        overrun <= 1'b1;
    end
  end

  // Serializer FSM; data_out/tx_start are loaded on entry to START so they
  // are valid in the START cycle and data_out holds until the next START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      data_out <= 8'h00;
      tx_start <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            sh       <= pend;
            cnt      <= '0;
            data_out <= pend[W-1 -: 8];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx_busy)
            state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (cnt == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              sh       <= sh_next;
              cnt      <= cnt + CW'(1);
              data_out <= sh_next[W-1 -: 8];
              tx_start <= 1'b1;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ungrouper.md
UNGROUPER -- requirements
Module: ungrouper

Interface
REQ-001 Parameter: BYTES, default 16, bytes per word; word width W = 8*BYTES.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset. Ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  W  word to serialize; the most significant byte is sent first.
- w_en  input  1  one-cycle load strobe for data_in.
- ready  output  1  the word buffer is empty and a w_en will be accepted.
- data_out  output  8  byte presented to the UART transmitter.
- tx_start  output  1  one-cycle request for the transmitter to send data_out.
- tx_busy  input  1  high while the transmitter is shifting a byte.
- busy  output  1  serialization in progress (state is not IDLE).
- done  output  1  one-cycle pulse after the last byte of a word has completed.
- overrun  output  1  sticky flag: a w_en arrived while ready=0.

Function
REQ-003 Word buffer (pend, pend_valid). The block SHALL register ready as !pend_valid.
REQ-004 w_en with ready=1 SHALL capture data_in into pend and set pend_valid on the next edge.
REQ-005 w_en with ready=0 SHALL be ignored, SHALL leave pend unchanged, and SHALL set overrun.
REQ-006 overrun SHALL clear only on rst.
REQ-007 FSM states SHALL be IDLE, START, WAIT_HI and WAIT_LO.
REQ-008 IDLE with pend_valid=1: the block SHALL copy pend to shift register sh, clear pend_valid, set byte counter cnt=0, and go to START.
REQ-009 START: data_out SHALL be sh[W-1:W-8], tx_start SHALL be 1 for exactly this cycle, and the next state SHALL be WAIT_HI.
REQ-010 WAIT_HI: the FSM SHALL stay until tx_busy=1, then go to WAIT_LO.
REQ-011 WAIT_LO: the FSM SHALL stay until tx_busy=0.
- If cnt<BYTES-1: sh shifts left by 8, cnt increments, next state START.
- If cnt=BYTES-1: done=1 for one cycle, next state IDLE.
REQ-012 data_out SHALL hold its value from each START until the next START; it SHALL NOT change while tx_busy=1.
REQ-013 Byte order: byte k (k=0..BYTES-1) sent SHALL equal data_in[W-1-8k : W-8-8k].
REQ-014 While a word is serializing, a new word SHALL be acceptable into pend (one-word prefetch).
REQ-015 After done, a pending word SHALL start with exactly one IDLE cycle between the done cycle and the next tx_start.
REQ-016 w_en in the same cycle as the IDLE pend-to-sh transfer SHALL see ready=0 and is therefore ignored, flagging overrun.
REQ-017 cnt SHALL be ceil(log2(BYTES)) bits and SHALL never exceed BYTES-1; there SHALL be no wrap past the last byte.
REQ-018 busy SHALL be 1 in START, WAIT_HI and WAIT_LO, and 0 in IDLE.
REQ-019 tx_busy activity while in IDLE SHALL have no effect.
REQ-020 The block SHALL have no timeout; a tx_busy stuck at 1 holds the FSM in WAIT_LO indefinitely.

Reset
REQ-021 rst=1 SHALL asynchronously force:
- state=IDLE, pend_valid=0, ready=1;
- sh=0, cnt=0;
- data_out=0x00, tx_start=0, done=0, busy=0, overrun=0.
REQ-022 rst asserted mid-word SHALL abandon the word and the prefetched word with no further tx_start.
REQ-023 The first w_en SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-024 BYTES=16, load data_in=0x000102...0F, with a tx model that raises tx_busy 1 cycle after tx_start for 10 cycles -> bytes 0x00..0x0F emitted in order, 16 tx_start pulses, and a single done pulse after byte 0x0F.
REQ-025 Load word A, then load word B during byte 3 of A -> B accepted with ready returning to 0; after A's done, one IDLE cycle, then B byte 0 on tx_start; overrun stays 0.
REQ-026 Load A, load B, then a third w_en while B is pending -> overrun=1 and the third word discarded; the output byte stream is exactly A followed by B.
REQ-027 Hold tx_busy=1 for 50 cycles after a tx_start -> no new tx_start and data_out stable; resumes within 1 cycle of tx_busy falling.
REQ-028 Assert rst during WAIT_LO of byte 7 with a word pending -> all outputs at reset values immediately; no tx_start afterwards until a new w_en.
REQ-029 BYTES=2, data_in=0xA55A -> data_out 0xA5 then 0x5A; done follows the second byte.
